// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//
// Elastic pipeline register for an inter-stage boundary (IF/ID, ID/EX, EX/MEM,
// MEM/WB). It carries a payload, a control word and a monitor commit bit.
// Transfers use a valid/ready handshake.
//
// A two-entry buffer holds the entries:
//   - Main slot M drives out_*.
//   - Skid slot S catches the entry accepted in the cycle that downstream
//     stalls.
// Because of the skid slot, in_ready is a plain register (in_ready == S empty)
// with no combinational path from out_ready.
//
// Flush squashes every entry that is still held after the clock edge, plus
// any entry accepted in the same cycle. The effect depends on FLUSH_MODE:
//   - 0: drop the entries.
//   - 1: keep the entries as bubbles (ctrl = NOP_CTRL, data = 0, commit = 0).
//
// Parameters:
//   DATA_W      payload width
//   CTRL_W      control word width
//   NOP_CTRL    control word of a bubble; also the reset value of ctrl
//   FLUSH_MODE  0 = drop flushed entries, 1 = convert them to bubbles
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-low reset
//   in_valid    upstream entry present
//   in_ready    stage can accept (registered, == skid slot empty)
//   in_data     upstream payload
//   in_ctrl     upstream control word
//   in_commit   upstream monitor commit bit
//   flush       squash held entries and any entry accepted this cycle
//   out_valid   head entry present
//   out_ready   downstream accepts the head
//   out_data    head payload
//   out_ctrl    head control word
//   out_commit  head commit bit
//   occupancy   number of held entries (0..2)
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned        DATA_W     = 96,
  parameter int unsigned        CTRL_W     = 48,
  parameter logic [CTRL_W-1:0]  NOP_CTRL   = '0,
  parameter bit                 FLUSH_MODE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_commit,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_commit,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic              commit;
  } slot_t;

  localparam slot_t EMPTY_SLOT = '{valid: 1'b0, data: '0, ctrl: NOP_CTRL, commit: 1'b0};

  slot_t m_q, m_d;
  slot_t s_q, s_d;
  slot_t in_entry;
  logic  in_ready_q, in_ready_d;
  logic  in_fire, out_fire;

  // Apply a flush to one next-state slot.
  function automatic slot_t squash(input slot_t e);
    slot_t r;
    r = e;
    if (FLUSH_MODE) begin
      if (e.valid) begin
        r.data   = '0;
        r.ctrl   = NOP_CTRL;
        r.commit = 1'b0;
      end
    end else begin
      r.valid  = 1'b0;
      r.commit = 1'b0;
    end
    return r;
  endfunction

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = m_q.valid & out_ready;

  always_comb begin
    // NOTE: every variable written here gets a default first, so a path that
    // misses an assignment holds the register value instead of inferring a latch.
    in_entry = '{valid: 1'b1, data: in_data, ctrl: in_ctrl, commit: in_commit};
    m_d      = m_q;
    s_d      = s_q;

    if (!m_q.valid || (out_fire && !s_q.valid)) begin
      // Main slot is free, or it is being emptied with nothing waiting behind it.
      if (in_fire) begin
        m_d = in_entry;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (out_fire) begin
      // Head popped while the skid slot is full: promote the skid slot.
      // in_ready is low in this state, so nothing is accepted concurrently.
      m_d       = s_q;
      s_d.valid = 1'b0;
    end else if (in_fire) begin
      // Head stalled: the accepted entry lands in the skid slot.
      s_d = in_entry;
    end

    // The next-state slots contain exactly the entries that survive the edge.
    // A head popped this cycle is already gone, so it leaves unmodified.
    if (flush) begin
      m_d = squash(m_d);
      s_d = squash(s_d);
    end

    if (!m_d.valid) m_d.commit = 1'b0;
    if (!s_d.valid) s_d.commit = 1'b0;

    in_ready_d = !s_d.valid;
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments, so every register samples
    // values from before the edge regardless of statement order.
    if (!rst) begin
      // NOTE: the payload registers are reset too, because out_data and out_ctrl
      // have defined values (0 / NOP_CTRL) after reset.
      m_q        <= EMPTY_SLOT;
      s_q        <= EMPTY_SLOT;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = m_q.valid;
  assign out_data   = m_q.data;
  assign out_ctrl   = m_q.ctrl;
  assign out_commit = m_q.commit;
  assign occupancy  = {1'b0, m_q.valid} + {1'b0, s_q.valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Self-checking bench for pipe_stage_reg. Two instances share one stimulus:
//   - u1 uses FLUSH_MODE=1 (bubbles).
//   - u0 uses FLUSH_MODE=0 (drop).
//
// A table of directed vectors covers reset, streaming, skid/back-pressure and
// reset in the middle of operation. Hand-written sequences cover the flush
// corner cases.
//
// Stimulus encoding: entry d carries
//   data   = {d, 80'h0, d}
//   ctrl   = {32'h0, 8'h5A, d}
//   commit = 1
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int          DW  = 96;
  localparam int          CW  = 48;
  localparam logic [47:0] NOP = 48'h00AB_CDEF_1234;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          in_commit;
  logic          flush;
  logic          out_ready;

  logic          ir1, v1, cm1;
  logic [DW-1:0] d1;
  logic [CW-1:0] c1;
  logic [1:0]    o1;

  logic          ir0, v0, cm0;
  logic [DW-1:0] d0;
  logic [CW-1:0] c0;
  logic [1:0]    o0;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .FLUSH_MODE(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_commit(in_commit),
    .flush(flush), .out_valid(v1), .out_ready(out_ready),
    .out_data(d1), .out_ctrl(c1), .out_commit(cm1), .occupancy(o1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NOP_CTRL(NOP), .FLUSH_MODE(1'b0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_ctrl(in_ctrl), .in_commit(in_commit),
    .flush(flush), .out_valid(v0), .out_ready(out_ready),
    .out_data(d0), .out_ctrl(c0), .out_commit(cm0), .occupancy(o0)
  );

  function automatic logic [DW-1:0] data_of(input logic [7:0] d);
    return {d, 80'h0, d};
  endfunction

  function automatic logic [CW-1:0] ctrl_of(input logic [7:0] d);
    return {32'h0, 8'h5A, d};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare one instance's outputs against the expected values.
  // Payload (data, ctrl) is compared only when chk_pl is set.
  task automatic check_dut(input string tag, input bit which,
                           input logic ev, input logic [DW-1:0] ed,
                           input logic [CW-1:0] ec, input logic ecm,
                           input logic [1:0] eocc, input logic eir,
                           input bit chk_pl);
    logic          av, acm, air;
    logic [DW-1:0] ad;
    logic [CW-1:0] ac;
    logic [1:0]    ao;
    string         t;
    if (which) begin
      av = v1; ad = d1; ac = c1; acm = cm1; ao = o1; air = ir1; t = {tag, "/u1"};
    end else begin
      av = v0; ad = d0; ac = c0; acm = cm0; ao = o0; air = ir0; t = {tag, "/u0"};
    end
    check({t, ".out_valid"},  128'(av),  128'(ev));
    check({t, ".occupancy"},  128'(ao),  128'(eocc));
    check({t, ".in_ready"},   128'(air), 128'(eir));
    check({t, ".out_commit"}, 128'(acm), 128'(ecm));
    if (chk_pl) begin
      check({t, ".out_data"}, 128'(ad), 128'(ed));
      check({t, ".out_ctrl"}, 128'(ac), 128'(ec));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [7:0] d, input logic fl, input logic ordy);
    rst       = 1'b1;
    in_valid  = iv;
    in_data   = data_of(d);
    in_ctrl   = ctrl_of(d);
    in_commit = iv;
    flush     = fl;
    out_ready = ordy;
  endtask

  // Expect a live entry d at the head.
  task automatic exp_entry(input string tag, input bit which, input logic [7:0] d,
                           input logic [1:0] eocc, input logic eir);
    check_dut(tag, which, 1'b1, data_of(d), ctrl_of(d), 1'b1, eocc, eir, 1'b1);
  endtask

  // Expect a bubble at the head.
  task automatic exp_bubble(input string tag, input bit which,
                            input logic [1:0] eocc, input logic eir);
    check_dut(tag, which, 1'b1, '0, NOP, 1'b0, eocc, eir, 1'b1);
  endtask

  // Expect an empty stage.
  task automatic exp_empty(input string tag, input bit which);
    check_dut(tag, which, 1'b0, '0, NOP, 1'b0, 2'd0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic       rst_n;
    logic       iv;
    logic [7:0] d;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic [1:0] eocc;
    logic       eir;
    logic       rst_chk;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic iv, input logic [7:0] d,
                              input logic ordy, input logic ev, input logic [7:0] ed,
                              input logic [1:0] eocc, input logic eir, input logic rc);
    vec_t v;
    v.rst_n = r;  v.iv = iv;     v.d   = d;   v.ordy    = ordy;
    v.ev    = ev; v.ed = ed;     v.eocc = eocc; v.eir   = eir; v.rst_chk = rc;
    return v;
  endfunction

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
    in_commit = 1'b0; flush = 1'b0; out_ready = 1'b0;

    // ---------------------------------------------------------------------
    // Table: expected values are the outputs after the edge.
    // Fields: rst, iv, d, ordy | ev, ed, occ, in_ready, reset-check
    // ---------------------------------------------------------------------

    // Reset held for 2 cycles with in_valid high.
    vecs.push_back(mk(0, 1, 8'h09, 1, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(0, 1, 8'h09, 1, 0, 8'h00, 0, 1, 1));

    // Streaming 1..8 with out_ready=1: each entry shows one cycle after acceptance.
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1, 1, 8'(k), 1, 1, 8'(k), 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0));  // empty: out_ready ignored

    // Skid: 0x11..0x16, out_ready low for 3 cycles once 0x12 is visible.
    vecs.push_back(mk(1, 1, 8'h11, 1, 1, 8'h11, 1, 1, 0));
    vecs.push_back(mk(1, 1, 8'h12, 1, 1, 8'h12, 1, 1, 0));
    vecs.push_back(mk(1, 1, 8'h13, 0, 1, 8'h12, 2, 0, 0));  // 0x13 goes to skid
    vecs.push_back(mk(1, 1, 8'h14, 0, 1, 8'h12, 2, 0, 0));  // full: in_valid ignored
    vecs.push_back(mk(1, 1, 8'h14, 0, 1, 8'h12, 2, 0, 0));
    vecs.push_back(mk(1, 1, 8'h14, 1, 1, 8'h13, 1, 1, 0));  // pop 0x12, skid -> main
    vecs.push_back(mk(1, 1, 8'h14, 1, 1, 8'h14, 1, 1, 0));
    vecs.push_back(mk(1, 1, 8'h15, 1, 1, 8'h15, 1, 1, 0));
    vecs.push_back(mk(1, 1, 8'h16, 1, 1, 8'h16, 1, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0));

    // Reset in the middle of operation discards both held entries.
    vecs.push_back(mk(1, 1, 8'h41, 0, 1, 8'h41, 1, 1, 0));
    vecs.push_back(mk(1, 1, 8'h42, 0, 1, 8'h41, 2, 0, 0));
    vecs.push_back(mk(0, 1, 8'h43, 0, 0, 8'h00, 0, 1, 1));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 8'h00, 0, 1, 0));

    foreach (vecs[i]) begin
      rst       = vecs[i].rst_n;
      in_valid  = vecs[i].iv;
      in_data   = data_of(vecs[i].d);
      in_ctrl   = ctrl_of(vecs[i].d);
      in_commit = vecs[i].iv;
      flush     = 1'b0;
      out_ready = vecs[i].ordy;
      tick();
      for (int w = 0; w < 2; w++) begin
        if (vecs[i].rst_chk)
          check_dut($sformatf("vec%0d", i), w[0], 1'b0, '0, NOP, 1'b0,
                    2'd0, 1'b1, 1'b1);
        else if (vecs[i].ev)
          exp_entry($sformatf("vec%0d", i), w[0], vecs[i].ed,
                    vecs[i].eocc, vecs[i].eir);
        else
          check_dut($sformatf("vec%0d", i), w[0], 1'b0, '0, NOP, 1'b0,
                    vecs[i].eocc, vecs[i].eir, 1'b0);
      end
    end

    // ---------------------------------------------------------------------
    // Flush with occupancy 2, no pop.
    // ---------------------------------------------------------------------
    drive(1, 8'h21, 0, 0); tick();
    exp_entry("fl2.a", 1, 8'h21, 1, 1); exp_entry("fl2.a", 0, 8'h21, 1, 1);
    drive(1, 8'h22, 0, 0); tick();
    exp_entry("fl2.b", 1, 8'h21, 2, 0); exp_entry("fl2.b", 0, 8'h21, 2, 0);
    drive(0, 8'h00, 1, 0); tick();
    exp_bubble("fl2.c", 1, 2, 0);       // both entries kept as bubbles
    exp_empty("fl2.c", 0);              // both entries dropped
    drive(0, 8'h00, 0, 1); tick();
    exp_bubble("fl2.d", 1, 1, 1);       // skid bubble promoted
    exp_empty("fl2.d", 0);
    drive(0, 8'h00, 0, 1); tick();
    exp_empty("fl2.e", 1); exp_empty("fl2.e", 0);

    // ---------------------------------------------------------------------
    // Flush with a simultaneous accept into an empty stage.
    // ---------------------------------------------------------------------
    drive(1, 8'h31, 1, 1); tick();
    exp_bubble("flin.a", 1, 1, 1);
    exp_empty("flin.a", 0);
    drive(0, 8'h00, 0, 1); tick();
    exp_empty("flin.b", 1); exp_empty("flin.b", 0);  // 0x31 never appears

    // ---------------------------------------------------------------------
    // Flush coincident with a pop of head 0xA5, skid holds 0xB6.
    // ---------------------------------------------------------------------
    drive(1, 8'hA5, 0, 0); tick();
    drive(1, 8'hB6, 0, 0); tick();
    exp_entry("flpop.a", 1, 8'hA5, 2, 0); exp_entry("flpop.a", 0, 8'hA5, 2, 0);
    drive(0, 8'h00, 1, 1); #1;
    // Head as seen by downstream in the popping cycle: unmodified by flush.
    exp_entry("flpop.b", 1, 8'hA5, 2, 0); exp_entry("flpop.b", 0, 8'hA5, 2, 0);
    tick();
    exp_bubble("flpop.c", 1, 1, 1);     // 0xB6 became a bubble
    exp_empty("flpop.c", 0);            // 0xB6 dropped
    drive(0, 8'h00, 0, 1); tick();
    exp_empty("flpop.d", 1); exp_empty("flpop.d", 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
